// File: rtl/srl32_tap_reg.sv
// srl32_tap_reg: 32-stage serial-in shift register.
// Q is an addressable read tap (stage A); Q31 is the cascade output (stage 31).
// CLR_N is an asynchronous active-low clear that reloads INIT.
// Build option: define SRL_REGOUT_EN to take Q from an output flop.
// That flop adds one cycle of latency to Q and is cleared to 0 by CLR_N.
// Q31 is unaffected by the option and stays combinational.
module srl32_tap_reg #(
   parameter logic [31:0] INIT          = 32'h0000_0000,
   parameter logic        IS_C_INVERTED = 1'b0,
   parameter logic        IS_D_INVERTED = 1'b0
) (
   input  logic       C,
   input  logic       CLR_N,
   input  logic       CE,
   input  logic       D,
   input  logic [4:0] A,
   output logic       Q,
   output logic       Q31
);

   logic        clk_act;
   logic        d_in;
   logic [31:0] sr_d;
   logic [31:0] sr_q;
   logic        tap;

   // IS_C_INVERTED is a constant, so this reduces to a wire or a single inverter.
   assign clk_act = C ^ IS_C_INVERTED;
   assign d_in    = D ^ IS_D_INVERTED;

   // Next contents: shift one stage toward 31 when enabled, otherwise hold.
   always_comb begin
      sr_d = sr_q;
      if (CE) begin
         sr_d = {sr_q[30:0], d_in};
      end
   end

   // Storage. Clear reloads INIT without a clock and blocks shifting while low.
   always_ff @(posedge clk_act or negedge CLR_N) begin
      if (!CLR_N) begin
         sr_q <= INIT;
      end else begin
         sr_q <= sr_d;
      end
   end

   // Read tap: explicit 32-way decode.
   // An unknown address selects no stage and reads 0, so X on A never reaches Q.
   always_comb begin
      tap = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (A == 5'(i)) begin
            tap = sr_q[i];
         end
      end
   end

`ifdef SRL_REGOUT_EN
   logic q_d;
   logic q_q;

   // The output flop samples the tap of the pre-edge contents on every active edge.
   // It does this regardless of CE, so a new address is still seen during a hold.
   always_comb begin
      q_d = tap;
   end

   // Output register; clear forces it to 0 rather than to an INIT bit.
   always_ff @(posedge clk_act or negedge CLR_N) begin
      if (!CLR_N) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q = q_q;
`else
   assign Q = tap;
`endif

   assign Q31 = sr_q[31];

endmodule

// File: tb/tb_srl32_tap_reg.sv
// Bench for srl32_tap_reg.
// It instantiates three copies of the design:
//   dut_a - INIT = A5A5_F00F
//   dut_b - INIT = 0
//   dut_c - INIT = 0, with the clock and the data input inverted
// Each copy is compared against a queue model of its stage contents.
module tb_srl32_tap_reg;

`ifdef SRL_REGOUT_EN
   localparam bit REGOUT = 1'b1;
   localparam int LAT    = 1;
`else
   localparam bit REGOUT = 1'b0;
   localparam int LAT    = 0;
`endif

   localparam logic [31:0] INIT_A = 32'hA5A5_F00F;
   localparam logic [31:0] INIT_B = 32'h0000_0000;
   localparam logic [31:0] INIT_C = 32'h0000_0000;

   logic       clk = 1'b0;
   logic       clr_n, ce, d;
   logic [4:0] a;
   logic       q_a, q31_a, q_b, q31_b;
   logic       clr_c, ce_c, d_c;
   logic [4:0] a_c;
   logic       q_c, q31_c;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: element 0 of each queue is stage 0.
   bit ma[$];
   bit mb[$];
   bit mc[$];
   bit qa_m, qb_m, qc_m;

   always #50 clk = ~clk;

   srl32_tap_reg #(.INIT(INIT_A)) dut_a (
      .C(clk), .CLR_N(clr_n), .CE(ce), .D(d), .A(a), .Q(q_a), .Q31(q31_a));

   srl32_tap_reg #(.INIT(INIT_B)) dut_b (
      .C(clk), .CLR_N(clr_n), .CE(ce), .D(d), .A(a), .Q(q_b), .Q31(q31_b));

   srl32_tap_reg #(.INIT(INIT_C), .IS_C_INVERTED(1'b1), .IS_D_INVERTED(1'b1)) dut_c (
      .C(clk), .CLR_N(clr_c), .CE(ce_c), .D(d_c), .A(a_c), .Q(q_c), .Q31(q31_c));

   task automatic load_ab();
      ma.delete();
      mb.delete();
      for (int i = 0; i < 32; i++) begin
         ma.push_back(INIT_A[i]);
         mb.push_back(INIT_B[i]);
      end
      qa_m = 1'b0;
      qb_m = 1'b0;
   endtask

   task automatic load_c();
      mc.delete();
      for (int i = 0; i < 32; i++) mc.push_back(INIT_C[i]);
      qc_m = 1'b0;
   endtask

   // Model for dut_a and dut_b, which shift on posedge.
   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         load_ab();
      end else begin
         qa_m = ma[a];
         qb_m = mb[a];
         if (ce) begin
            ma.push_front(d); void'(ma.pop_back());
            mb.push_front(d); void'(mb.pop_back());
         end
      end
   end

   // Model for dut_c, which shifts on negedge and stores the inverted data bit.
   always @(negedge clk or negedge clr_c) begin
      if (!clr_c) begin
         load_c();
      end else begin
         qc_m = mc[a_c];
         if (ce_c) begin
            mc.push_front(~d_c); void'(mc.pop_back());
         end
      end
   end

   function automatic logic eq_a();
`ifdef SRL_REGOUT_EN
      return qa_m;
`else
      return ma[a];
`endif
   endfunction

   function automatic logic eq_b();
`ifdef SRL_REGOUT_EN
      return qb_m;
`else
      return mb[a];
`endif
   endfunction

   function automatic logic eq_c();
`ifdef SRL_REGOUT_EN
      return qc_m;
`else
      return mc[a_c];
`endif
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_ab(input string tag);
      chk({tag, "_qa"},   q_a,   eq_a());
      chk({tag, "_qb"},   q_b,   eq_b());
      chk({tag, "_q31a"}, q31_a, ma[31]);
      chk({tag, "_q31b"}, q31_b, mb[31]);
   endtask

   // One clock cycle for dut_a/dut_b.
   // Inputs change just after negedge; the task returns 1 time unit after posedge.
   task automatic cyc(input logic ce_v, input logic d_v, input logic [4:0] a_v);
      @(negedge clk);
      #1;
      ce = ce_v;
      d  = d_v;
      a  = a_v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] pat;
      logic [31:0] init_a_v;
      logic [4:0]  hold_addr [5];

      pat      = 32'hDEAD_BEEF;
      init_a_v = INIT_A;
      hold_addr[0] = 5'd0;
      hold_addr[1] = 5'd4;
      hold_addr[2] = 5'd31;
      hold_addr[3] = 5'd15;
      hold_addr[4] = 5'd8;

      clr_n = 1'b1; ce = 1'b0; d = 1'b0; a = 5'd0;
      clr_c = 1'b1; ce_c = 1'b0; d_c = 1'b0; a_c = 5'd0;

      // Reset state while clear is held low.
      #2;
      clr_n = 1'b0;
      clr_c = 1'b0;
      #1;
      chk("rst_q31_a", q31_a, 1'b1);
      chk("rst_q31_b", q31_b, 1'b0);
      chk("rst_q31_c", q31_c, 1'b0);
      chk("rst_q_a0",  q_a, REGOUT ? 1'b0 : 1'b1);
      a = 5'd4;
      #1;
      chk("rst_q_a4",  q_a, 1'b0);
      chk("rst_q_a4m", q_a, eq_a());

      // A clock edge while clear is low must not shift.
      ce = 1'b1;
      d  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_q31_b", q31_b, 1'b0);
      check_ab("rst_edge");

      @(negedge clk);
      #1;
      ce = 1'b0;
      clr_n = 1'b1;
      clr_c = 1'b1;

      // Hold: CE=0 for 5 edges leaves every tap at INIT.
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b1, hold_addr[k]);
         check_ab("hold");
         chk("hold_tap_a", q_a, init_a_v[a]);
      end

      // Walking one through the zero-initialised copy.
      cyc(1'b1, 1'b1, 5'd0);
      check_ab("walk1");
      chk("walk_q_a0", q_b, REGOUT ? 1'b0 : 1'b1);
      for (int e = 2; e <= 33; e++) begin
         cyc(1'b1, 1'b0, 5'd7);
         check_ab("walk");
         if (e == 7 + LAT)  chk("walk_q7_early", q_b, 1'b0);
         if (e == 8 + LAT)  chk("walk_q7_hit",   q_b, 1'b1);
         if (e == 31)       chk("walk_q31_pre",  q31_b, 1'b0);
         if (e == 32)       chk("walk_q31_rise", q31_b, 1'b1);
         if (e == 33)       chk("walk_q31_fall", q31_b, 1'b0);
      end

      // Load DEAD_BEEF MSB first, then read every tap back.
      for (int i = 31; i >= 0; i--) begin
         cyc(1'b1, pat[i], 5'd0);
         check_ab("pat_load");
      end
      ce = 1'b0;
`ifdef SRL_REGOUT_EN
      for (int i = 0; i < 32; i++) begin
         cyc(1'b0, 1'b0, 5'(i));
         chk("pat_sweep", q_b, pat[i]);
         chk("pat_sweep_m", q_b, eq_b());
      end
`else
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         a = 5'(i);
         #1;
         chk("pat_sweep", q_b, pat[i]);
         chk("pat_sweep_m", q_b, eq_b());
      end
`endif

      // Mid-stream clear between edges, then the first edge after release shifts.
      for (int k = 0; k < 10; k++) begin
         cyc(1'b1, 1'b1, 5'd0);
         check_ab("ones");
      end
      @(negedge clk);
      #1;
      ce = 1'b0;
      clr_n = 1'b0;
      #1;
      chk("clr_q31_a", q31_a, 1'b1);
      chk("clr_q31_b", q31_b, 1'b0);
      for (int i = 0; i < 32; i++) begin
         a = 5'(i);
         #1;
         chk("clr_tap_b", q_b, 1'b0);
         chk("clr_tap_a", q_a, eq_a());
      end
      chk("clr_q_a31", q_a, REGOUT ? 1'b0 : 1'b1);
      ce = 1'b1;
      d  = 1'b1;
      a  = 5'd0;
      #2;
      clr_n = 1'b1;
      @(posedge clk);
      #1;
      check_ab("post_clr1");
      chk("post_clr_q0", q_b, REGOUT ? 1'b0 : 1'b1);
      cyc(1'b1, 1'b0, 5'd0);
      check_ab("post_clr2");
      chk("post_clr_q0b", q_b, REGOUT ? 1'b1 : 1'b0);

      // Randomised traffic on dut_a and dut_b.
      for (int k = 0; k < 300; k++) begin
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
         check_ab("rand");
      end

      // Inverted clock and data: shift on negedge, D=0 stores 1.
      ce_c = 1'b1;
      d_c  = 1'b0;
      a_c  = 5'd0;
      @(negedge clk);
      #1;
      chk("inv_neg_q",    q_c, REGOUT ? 1'b0 : 1'b1);
      chk("inv_neg_qm",   q_c, eq_c());
      chk("inv_neg_q31",  q31_c, 1'b0);
      a_c = 5'd1;
      #1;
      chk("inv_neg_q1",   q_c, 1'b0);
      @(posedge clk);
      #1;
      chk("inv_pos_q1",   q_c, 1'b0);
      chk("inv_pos_qm",   q_c, eq_c());
      a_c = 5'd0;
      #1;
      chk("inv_pos_q0",   q_c, REGOUT ? 1'b0 : 1'b1);
      ce_c = 1'b0;
      @(negedge clk);
      #1;
      chk("inv_hold_q",   q_c, 1'b1);
      chk("inv_hold_qm",  q_c, eq_c());
      chk("inv_hold_q31", q31_c, mc[31]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
